fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the memory-controller cache. Holds the PC and issues one-word fetch requests over the cache's fetcher handshake. Predecodes each returned word for next-PC prediction and buffers instructions in a small queue feeding the decoder. Flushes and redirects on rob_clear.

Parameters:
IQ_DEPTH, 4, instruction queue entries; must be a power of 2 and at least 2.
RESET_PC, 32'h0, PC value after reset.
BHT_IDX_W, 6, BHT index width; used only with FETCH_BHT_EN.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
rdy  in  1  global enable; low freezes all state
rob_clear  in  1  misprediction flush
rob_redirect_pc  in  32  PC to restart from on rob_clear
mem_req  out  1  fetch request; drives cache in_fetcher_ready
mem_addr  out  32  fetch address; drives cache instr_addr
mem_ready  in  1  one-cycle response pulse from cache out_fetcher_ready
mem_instr  in  32  returned instruction word
mem_instr_addr  in  32  address of the returned word
dec_ready  in  1  decoder can accept
dec_valid  out  1  queue head valid
dec_instr  out  32  queue head instruction
dec_pc  out  32  queue head PC
dec_pred_taken  out  1  predicted-taken flag for the head
dec_pred_pc  out  32  predicted next PC for the head
br_upd_valid  in  1  branch resolved (ignored without FETCH_BHT_EN)
br_upd_pc  in  32  resolved branch PC
br_upd_taken  in  1  resolved branch direction

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, queue empty, mem_req=0 for the reset cycle, dec_valid=0, dec_instr/dec_pc/dec_pred_pc=0, dec_pred_taken=0.
- mem_addr = pc register at all times. The fetcher holds one outstanding request at most.
- FSM has two states:
  - FETCH: mem_req=1. The cache latches the address on a cycle it is idle. The request stays high until mem_ready.
  - HOLD: mem_req=0. Entered when the queue is full.
- On a mem_ready cycle with mem_instr_addr==pc:
  - Push {mem_instr, pc, taken, next}.
  - pc <= next.
  - Next state is FETCH if the queue count after this cycle is below IQ_DEPTH, otherwise HOLD.
  - mem_req stays high through the response cycle; the cache does not re-accept during that cycle, so the new pc is presented the following cycle.
- A mem_ready whose address does not match pc is dropped; no push.
- HOLD returns to FETCH the cycle after a pop makes count < IQ_DEPTH.
- Next-PC predecode uses opcode mem_instr[6:0]:
  - JAL 7'b1101111: taken=1, next = pc + sign-extended J-immediate {imm[20|10:1|11|19:12],0}.
  - BRANCH 7'b1100011: taken=0, next=pc+4 (static not-taken).
  - Everything else, including JALR: taken=0, next=pc+4.
  - All adds are 32-bit modulo 2^32.
- Queue: circular, separate head/tail pointers plus a count of width log2(IQ_DEPTH)+1. Pop on dec_valid&&dec_ready. Push and pop in the same cycle leave count unchanged; this is legal when full.
- Latency: a pushed entry is visible on dec_* the cycle after mem_ready (response→decoder = 1 cycle).
- dec_* outputs come from the head register; when empty, dec_valid=0 and the data outputs hold their last value.
- rob_clear has priority over everything except rst:
  - Queue is flushed (count=0, pointers=0, dec_valid=0 next cycle).
  - pc <= rob_redirect_pc, state <= FETCH, mem_req=0 in the clear cycle.
  - Any in-flight response is abandoned; the cache resets in the same cycle.
  - A mem_ready arriving in the clear cycle is ignored.
- rst has priority over rob_clear. rdy=0 holds all registers; outputs stay stable.

Optional Feature:
FETCH_BHT_EN:
- Defined:
  - Adds a 2^BHT_IDX_W-entry table of 2-bit saturating counters, indexed pc[BHT_IDX_W+1:2], reset to 2'b01 (weakly not-taken).
  - A BRANCH predicts taken when counter[1]=1, with next = pc + B-immediate.
  - br_upd_valid increments the counter at br_upd_pc's index if taken, otherwise decrements it, saturating at 0 and 3.
  - An update and a lookup on the same index in the same cycle: the lookup sees the old value.
- Undefined: static not-taken; br_upd_* are ignored and no table is instantiated.

Decomposition:
- Shared package fetch_pkg holds:
  - opcode constants OPC_JAL, OPC_JALR, OPC_BRANCH;
  - immediate-extract functions imm_j and imm_b;
  - the queue-entry field widths.
- One natural sub-module: fetch_queue, a parameterised FIFO with push/pop/full/empty and flush.

Test Plan:
1. Reset, then a 3-cycle memory model returning 32'h00000013 (nop) at 0,4,8 with dec_ready=1 → mem_addr sequence 0,4,8; dec_pc 0,4,8; dec_pred_taken=0.
2. Word at 0x10 = 32'h0100006F (jal x0,+16) → dec_pred_taken=1, dec_pred_pc=0x20; next mem_addr=0x20.
3. dec_ready=0 for 20 cycles → exactly IQ_DEPTH=4 entries pushed, mem_req=0 in HOLD; one pop → mem_req=1 the next cycle and the fetch resumes at the correct pc.
4. rob_clear with rob_redirect_pc=0x100 while a request is outstanding and the queue is holding 3 entries → dec_valid=0 next cycle, mem_addr=0x100; the stale response at the old address is not pushed.
5. Push and pop in the same cycle while full → count stays 4, order preserved.
6. FETCH_BHT_EN: two br_upd taken at 0x40, then fetch beq at 0x40 with imm=-8 → dec_pred_taken=1, dec_pred_pc=0x38.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, opcode constants and immediate decoders for the fetch stage.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam int ENTRY_W = INSTR_W + PC_W + 1 + PC_W;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic {FETCH, HOLD} state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               taken;
      logic [PC_W-1:0]    pred_pc;
   } iq_entry_t;

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue with a registered head so the decoder sees
// a new entry one cycle after it is pushed.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count_next
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    head_ptr, tail_ptr, head_ptr_nxt;
   logic [CW-1:0]    count, count_after_pop;
   logic             do_push, do_pop;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] head_nxt;

   assign empty           = (count == '0);
   assign full            = (count == CW'(DEPTH));
   assign do_pop          = pop && !empty;
   assign do_push         = push && (!full || do_pop);
   assign count_after_pop = count - CW'(do_pop);
   assign head_ptr_nxt    = head_ptr + PW'(do_pop);

   always_comb begin
      count_next = count_after_pop + CW'(do_push);
      if (flush) count_next = '0;
   end

   // When the queue drains to nothing this cycle the pushed word becomes the head.
   assign head_nxt = (count_after_pop == '0) ? push_data : mem[head_ptr_nxt];

   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr  <= '0;
         tail_ptr  <= '0;
         count     <= '0;
         head_data <= '0;
      end else if (rdy) begin
         if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
         end else begin
            if (do_push) tail_ptr <= tail_ptr + PW'(1);
            head_ptr <= head_ptr_nxt;
            count    <= count_next;
            if (count_next != '0) head_data <= head_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && !flush && do_push) mem[tail_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-outstanding fetch handshake, next-PC predecode,
// instruction queue. Optional branch history table under FETCH_BHT_EN.
//
// state | meaning
// FETCH | mem_req high, waiting for the response matching pc
// HOLD  | queue full, no request until an entry is popped
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          IQ_DEPTH  = 4,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          BHT_IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rob_clear,
   input  logic [31:0] rob_redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_instr,
   input  logic [31:0] mem_instr_addr,
   input  logic        dec_ready,
   output logic        dec_valid,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic        dec_pred_taken,
   output logic [31:0] dec_pred_pc,
   input  logic        br_upd_valid,
   input  logic [31:0] br_upd_pc,
   input  logic        br_upd_taken
);

   localparam int CW = $clog2(IQ_DEPTH) + 1;

   state_t               state;
   logic [31:0]          pc, pred_next;
   logic                 pred_taken, branch_taken;
   logic                 pc_hit, iq_push, iq_pop, iq_full, iq_empty;
   logic [CW-1:0]        iq_count_next;
   logic [ENTRY_W-1:0]   head_bits;
   iq_entry_t            push_entry, head_entry;

`ifdef FETCH_BHT_EN
   logic [1:0]           bht [2**BHT_IDX_W];
   logic [BHT_IDX_W-1:0] upd_idx;

   assign upd_idx      = br_upd_pc[BHT_IDX_W+1:2];
   // Combinational lookup: a same-cycle update to this index is not yet visible.
   assign branch_taken = bht[pc[BHT_IDX_W+1:2]][1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
      end else if (rdy && br_upd_valid) begin
         if (br_upd_taken && bht[upd_idx] != 2'b11)
            bht[upd_idx] <= bht[upd_idx] + 2'b01;
         else if (!br_upd_taken && bht[upd_idx] != 2'b00)
            bht[upd_idx] <= bht[upd_idx] - 2'b01;
      end
   end

   logic unused_upd_bits;
   assign unused_upd_bits = ^{br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0]};
`else
   localparam int unused_bht_w = BHT_IDX_W;
   logic unused_bht;
   assign branch_taken = 1'b0;
   assign unused_bht   = ^{br_upd_valid, br_upd_taken, br_upd_pc};
`endif

   always_comb begin
      pred_taken = 1'b0;
      pred_next  = pc + 32'd4;
      case (mem_instr[6:0])
         OPC_JAL: begin
            pred_taken = 1'b1;
            pred_next  = pc + imm_j(mem_instr);
         end
         OPC_BRANCH: begin
            if (branch_taken) begin
               pred_taken = 1'b1;
               pred_next  = pc + imm_b(mem_instr);
            end
         end
         OPC_JALR: ;
         default: ;
      endcase
   end

   assign pc_hit     = mem_ready && (mem_instr_addr == pc);
   assign iq_pop     = !iq_empty && dec_ready;
   assign iq_push    = pc_hit && !rob_clear && (!iq_full || iq_pop);
   assign push_entry = '{instr: mem_instr, pc: pc, taken: pred_taken, pred_pc: pred_next};

   fetch_queue #(.DEPTH(IQ_DEPTH), .WIDTH(ENTRY_W)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .flush      (rob_clear),
      .push       (iq_push),
      .push_data  (push_entry),
      .pop        (iq_pop),
      .head_data  (head_bits),
      .full       (iq_full),
      .empty      (iq_empty),
      .count_next (iq_count_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         state   <= FETCH;
         mem_req <= 1'b0;
      end else if (rdy) begin
         if (rob_clear) begin
            // Drop the request for a cycle so the cache restarts cleanly.
            pc      <= rob_redirect_pc;
            state   <= FETCH;
            mem_req <= 1'b0;
         end else begin
            if (iq_push) pc <= pred_next;
            if (iq_count_next == CW'(IQ_DEPTH)) begin
               state   <= HOLD;
               mem_req <= 1'b0;
            end else begin
               state   <= FETCH;
               mem_req <= 1'b1;
            end
         end
      end
   end

   assign head_entry     = head_bits;
   assign mem_addr       = pc;
   assign dec_valid      = !iq_empty;
   assign dec_instr      = head_entry.instr;
   assign dec_pc         = head_entry.pc;
   assign dec_pred_taken = head_entry.taken;
   assign dec_pred_pc    = head_entry.pred_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 3-cycle memory model feeds responses,
// expected queue entries are compared as the decoder pops them.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        rob_clear = 1'b0;
   logic [31:0] rob_redirect_pc = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_instr = '0;
   logic [31:0] mem_instr_addr = '0;
   logic        dec_ready = 1'b0;
   logic        dec_valid;
   logic [31:0] dec_instr, dec_pc, dec_pred_pc;
   logic        dec_pred_taken;
   logic        br_upd_valid = 1'b0;
   logic [31:0] br_upd_pc = '0;
   logic        br_upd_taken = 1'b0;

   fetch_unit #(.IQ_DEPTH(4), .RESET_PC(32'h0), .BHT_IDX_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .rob_clear(rob_clear), .rob_redirect_pc(rob_redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_instr_addr(mem_instr_addr),
      .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_instr(dec_instr),
      .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken), .dec_pred_pc(dec_pred_pc),
      .br_upd_valid(br_upd_valid), .br_upd_pc(br_upd_pc), .br_upd_taken(br_upd_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] pred;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_log[$];
   logic [31:0] exp_pc = 32'h0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic        mem_en = 1'b1;
   bit          busy = 0;
   int          cnt = 0;
   logic [31:0] lat_addr = '0;
   bit          seen40 = 0;
   logic        taken40 = 1'b0;
`ifdef FETCH_BHT_EN
   logic [1:0]  bht_m [64];
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h10:  return 32'h0100006F;   // jal x0, +16
         32'h40:  return 32'hFE000CE3;   // beq x0, x0, -8
         default: return 32'h00000013;   // nop
      endcase
   endfunction

   task automatic sb_push(input logic [31:0] a, input logic [31:0] ins);
      exp_t e;
      logic br_t;
      br_t = 1'b0;
`ifdef FETCH_BHT_EN
      br_t = bht_m[a[7:2]][1];
`endif
      e.instr = ins;
      e.pc    = a;
      e.taken = 1'b0;
      e.pred  = a + 32'd4;
      if (ins[6:0] == 7'h6F) begin
         e.taken = 1'b1;
         e.pred  = a + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end else if (ins[6:0] == 7'h63 && br_t) begin
         e.taken = 1'b1;
         e.pred  = a + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      exp_q.push_back(e);
      exp_pc = e.pred;
   endtask

   // Memory model: accepts on an idle cycle, answers three cycles later.
   initial forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
         mem_ready = 1'b0;
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy           = 0;
               mem_ready      = 1'b1;
               mem_instr      = mem_word(lat_addr);
               mem_instr_addr = lat_addr;
               if (lat_addr == exp_pc) sb_push(lat_addr, mem_instr);
            end
         end else if (mem_req && !rst) begin
            busy     = 1;
            cnt      = 3;
            lat_addr = mem_addr;
            addr_log.push_back(mem_addr);
         end
      end
   end

   // Decoder-side monitor.
   initial forever begin
      @(negedge clk);
      if (!rst && rdy && !rob_clear && dec_valid && dec_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_pending", exp_q.size(), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("dec_instr", dec_instr, e.instr);
            chk("dec_pc", dec_pc, e.pc);
            chk("dec_taken", {31'b0, dec_pred_taken}, {31'b0, e.taken});
            chk("dec_pred_pc", dec_pred_pc, e.pred);
            if (e.pc == 32'h40 && !seen40) begin
               seen40  = 1;
               taken40 = dec_pred_taken;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] first_addrs [6];
      int n0;
      first_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20};
`ifdef FETCH_BHT_EN
      for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
`endif

      repeat (2) @(posedge clk);
      #2;
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_taken", {31'b0, dec_pred_taken}, 32'h0);
      chk("rst_dec_pred_pc", dec_pred_pc, 32'h0);

      rst          = 1'b0;
      dec_ready    = 1'b1;
      br_upd_valid = 1'b1;
      br_upd_pc    = 32'h40;
      br_upd_taken = 1'b1;
`ifdef FETCH_BHT_EN
      repeat (2) bht_m[16] = (bht_m[16] == 2'b11) ? 2'b11 : bht_m[16] + 2'b01;
`endif
      repeat (2) @(posedge clk);
      #2;
      br_upd_valid = 1'b0;

      for (int k = 0; k < 300 && addr_log.size() < 20; k++) begin
         @(posedge clk);
         #2;
      end
      chk("run_fetches", {31'b0, addr_log.size() >= 20}, 32'h1);
      for (int i = 0; i < 6; i++)
         if (i < addr_log.size()) chk("fetch_addr", addr_log[i], first_addrs[i]);

      // Stall the decoder until the queue fills.
      dec_ready = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      chk("hold_req", {31'b0, mem_req}, 32'h0);
      chk("hold_valid", {31'b0, dec_valid}, 32'h1);
      chk("hold_depth", exp_q.size(), 4);

      rdy       = 1'b0;
      dec_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("frz_addr", mem_addr, exp_pc);
      chk("frz_depth", exp_q.size(), 4);
      chk("frz_head", dec_pc, exp_q[0].pc);
      rdy = 1'b1;
      @(posedge clk);
      #2;
      dec_ready = 1'b0;
      chk("resume_req", {31'b0, mem_req}, 32'h1);
      chk("resume_addr", mem_addr, exp_pc);

      for (int k = 0; k < 30 && exp_q.size() < 4; k++) begin
         @(posedge clk);
         #2;
      end
      @(posedge clk);
      #2;
      chk("refill_req", {31'b0, mem_req}, 32'h0);

      // Push and pop in the same cycle while full.
      mem_en         = 1'b0;
      dec_ready      = 1'b1;
      mem_ready      = 1'b1;
      mem_instr      = mem_word(exp_pc);
      mem_instr_addr = exp_pc;
      sb_push(exp_pc, mem_instr);
      @(posedge clk);
      #2;
      dec_ready = 1'b0;
      mem_ready = 1'b0;
      mem_en    = 1'b1;
      chk("pp_req", {31'b0, mem_req}, 32'h0);
      chk("pp_valid", {31'b0, dec_valid}, 32'h1);
      chk("pp_depth", exp_q.size(), 4);

      // Flush while a request is outstanding and three entries are queued.
      dec_ready = 1'b1;
      @(posedge clk);
      #2;
      dec_ready = 1'b0;
      @(posedge clk);
      #2;
      chk("pre_clr_depth", exp_q.size(), 3);
      n0              = addr_log.size();
      rob_clear       = 1'b1;
      rob_redirect_pc = 32'h100;
      exp_q.delete();
      exp_pc = 32'h100;
      @(posedge clk);
      #2;
      rob_clear = 1'b0;
      chk("clr_valid", {31'b0, dec_valid}, 32'h0);
      chk("clr_addr", mem_addr, 32'h100);
      chk("clr_req", {31'b0, mem_req}, 32'h0);

      dec_ready = 1'b1;
      for (int k = 0; k < 200 && addr_log.size() < n0 + 8; k++) begin
         @(posedge clk);
         #2;
      end
      chk("clr_fetches", {31'b0, addr_log.size() >= n0 + 8}, 32'h1);
      if (addr_log.size() > n0) chk("clr_refetch", addr_log[n0], 32'h100);

      chk("seen_0x40", {31'b0, seen40}, 32'h1);
`ifdef FETCH_BHT_EN
      chk("bht_taken_0x40", {31'b0, taken40}, 32'h1);
`else
      chk("static_nt_0x40", {31'b0, taken40}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
